// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding and register-file geometry
// used by the hazard controller, decoder and writeback.
package pipe_ctrl_pkg;

  localparam int REGSZ  = 5;
  localparam int NREGS  = 32;
  localparam int FCNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/load_scoreboard.sv
// Busy bit per architectural register for loads still in flight; flags a
// load-use hazard when a live decode source is still busy.
module load_scoreboard #(
  parameter int REGSZ = pipe_ctrl_pkg::REGSZ,
  parameter int NREGS = pipe_ctrl_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [REGSZ-1:0] set_rd_i,
  input  logic             clr_en_i,
  input  logic [REGSZ-1:0] clr_rd_i,
  input  logic             valid_i,
  input  logic [REGSZ-1:0] rs1_i,
  input  logic             use_rs1_i,
  input  logic [REGSZ-1:0] rs2_i,
  input  logic             use_rs2_i,
  output logic             hazard_o
);
  import pipe_ctrl_pkg::*;

  logic [NREGS-1:0] busy_q, busy_d;

  // A set in the same cycle as a clear of the same register wins: the new
  // load's result is still outstanding even though the old one just retired.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      assign busy_d[gi] = (set_en_i && (set_rd_i == REGSZ'(gi))) ||
                          (busy_q[gi] && !(clr_en_i && (clr_rd_i == REGSZ'(gi))));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Query uses the registered vector, so a source matching this cycle's
  // writeback still stalls (the regfile has no write-through path).
  assign hazard_o = valid_i && ((use_rs1_i && busy_q[rs1_i]) ||
                                (use_rs2_i && busy_q[rs2_i]));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage core: turns icache, dcache,
// jump and load-use events into per-stage stall/bubble/flush controls.
module pipe_hazard_ctrl #(
  parameter int REGSZ     = pipe_ctrl_pkg::REGSZ,
  parameter int NREGS     = pipe_ctrl_pkg::NREGS,
  parameter int FLUSH_CYC = 1,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_done,
  input  logic              id_valid,
  input  logic [REGSZ-1:0]  id_rs1,
  input  logic [REGSZ-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REGSZ-1:0]  id_rd,
  input  logic              id_is_load,
  input  logic              ex_jmp,
  input  logic              mem_req,
  input  logic              mem_done,
  input  logic              wb_wr_en,
  input  logic [REGSZ-1:0]  wb_rd,
  output logic              pc_hold,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_stall,
  output logic              memwb_bubble,
  output logic              id_fire,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  import pipe_ctrl_pkg::*;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                lu_hazard;
  logic                mem_stall;
  logic                jmp_take;
  logic                sb_set;

  assign sb_set = id_fire && id_is_load;

  load_scoreboard #(
    .REGSZ (REGSZ),
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (sb_set),
    .set_rd_i  (id_rd),
    .clr_en_i  (wb_wr_en),
    .clr_rd_i  (wb_rd),
    .valid_i   (id_valid),
    .rs1_i     (id_rs1),
    .use_rs1_i (id_use_rs1),
    .rs2_i     (id_rs2),
    .use_rs2_i (id_use_rs2),
    .hazard_o  (lu_hazard)
  );

  // Controls are forced low while rst is held so the pipeline sees a clean
  // idle state in the same cycle reset arrives, whatever the inputs do.
  always_comb begin
    pc_hold      = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    id_fire      = 1'b0;
    jmp_take     = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    mem_stall    = (state_q == MEM_WAIT) || (mem_req && !mem_done);

    if (!rst) begin
      if (mem_stall) begin
        pc_hold      = 1'b1;
        ifid_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = !((state_q == MEM_WAIT) && mem_done);
        if (state_q != MEM_WAIT) begin
          state_d = MEM_WAIT;
        end else if (mem_done) begin
          // A flush window interrupted by the dcache wait resumes afterwards.
          state_d = (fcnt_q != '0) ? FLUSH : RUN;
        end
      end else if (state_q == FLUSH) begin
        ifid_flush = 1'b1;
        fcnt_d     = fcnt_q - FCNT_W'(1);
        if (fcnt_q <= FCNT_W'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      end else if (ex_jmp) begin
        jmp_take    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        fcnt_d      = FCNT_W'(FLUSH_CYC);
        state_d     = FLUSH;
      end else if (lu_hazard) begin
        pc_hold     = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end else if (!icache_done) begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
      end

      id_fire = id_valid && !lu_hazard && !mem_stall && !jmp_take && (state_q != FLUSH);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && !(&stall_cnt_q))  stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (jmp_take && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed control vectors for
// load-use, jump, dcache wait, x0, same-cycle set/clear, saturation and reset.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_done, id_valid, id_use_rs1, id_use_rs2, id_is_load;
  logic [RW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic          ex_jmp, mem_req, mem_done, wb_wr_en;
  logic          pc_hold, ifid_stall, ifid_flush, idex_bubble;
  logic          exmem_stall, memwb_bubble, id_fire;
  logic [PW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    outs;

  int n_cmp = 0;
  int n_mis = 0;

  pipe_hazard_ctrl #(
    .REGSZ(RW), .NREGS(32), .FLUSH_CYC(1), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .icache_done(icache_done), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_is_load(id_is_load), .ex_jmp(ex_jmp), .mem_req(mem_req),
    .mem_done(mem_done), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .pc_hold(pc_hold),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble), .id_fire(id_fire),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_hold, ifid_stall, ifid_flush, idex_bubble, exmem_stall, memwb_bubble, id_fire}
  assign outs = {pc_hold, ifid_stall, ifid_flush, idex_bubble, exmem_stall, memwb_bubble, id_fire};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: got %0h", tag, got);
    end
  endtask

  task automatic idle();
    icache_done = 1'b1; id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_is_load = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; wb_rd = '0;
    ex_jmp = 1'b0; mem_req = 1'b0; mem_done = 1'b0; wb_wr_en = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample the current cycle's controls on the falling edge, then advance.
  task automatic cyc_check(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check_val(tag, {25'd0, outs}, {25'd0, exp});
    next_cyc();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    next_cyc();
    rst = 1'b0;

    // Reset state with idle inputs
    @(negedge clk);
    check_val("rst_outs",  {25'd0, outs}, 32'd0);
    check_val("rst_stall", 32'(stall_cnt), 32'd0);
    check_val("rst_flush", 32'(flush_cnt), 32'd0);
    next_cyc();

    // Load x5, consumer stalls until the cycle after wb writes x5
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 5'd5;
    cyc_check("lu_load", 7'b0000001);
    id_is_load = 1'b0; id_rd = 5'd6; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    cyc_check("lu_stall0", 7'b1101000);
    cyc_check("lu_stall1", 7'b1101000);
    wb_wr_en = 1'b1; wb_rd = 5'd5;
    cyc_check("lu_wbcyc", 7'b1101000);
    wb_wr_en = 1'b0;
    @(negedge clk);
    check_val("lu_release", {25'd0, outs}, 32'b0000001);
    check_val("lu_stallcnt", 32'(stall_cnt), 32'd3);
    next_cyc();

    // Jump: two flush cycles, one bubble; a second jump inside FLUSH is ignored
    do_reset();
    ex_jmp = 1'b1;
    @(negedge clk);
    check_val("jmp_outs", {25'd0, outs}, 32'b0011000);
    check_val("jmp_cnt0", 32'(flush_cnt), 32'd0);
    next_cyc();
    cyc_check("jmp_flush", 7'b0010000);
    ex_jmp = 1'b0;
    @(negedge clk);
    check_val("jmp_done", {25'd0, outs}, 32'd0);
    check_val("jmp_cnt1", 32'(flush_cnt), 32'd1);
    next_cyc();

    // Dcache wait with ex_jmp held: 4 stalled cycles, jump only afterwards
    do_reset();
    mem_req = 1'b1; ex_jmp = 1'b1;
    for (int i = 0; i < 3; i++) cyc_check($sformatf("mw_wait%0d", i), 7'b1100110);
    mem_done = 1'b1;
    @(negedge clk);
    check_val("mw_done", {25'd0, outs}, 32'b1100100);
    check_val("mw_fcnt", 32'(flush_cnt), 32'd0);
    next_cyc();
    mem_req = 1'b0; mem_done = 1'b0;
    cyc_check("mw_jmp", 7'b0011000);
    ex_jmp = 1'b0;
    @(negedge clk);
    check_val("mw_flush", {25'd0, outs}, 32'b0010000);
    check_val("mw_fcnt1", 32'(flush_cnt), 32'd1);
    check_val("mw_scnt", 32'(stall_cnt), 32'd4);
    next_cyc();

    // Same-cycle mem_req and mem_done: no stall
    mem_req = 1'b1; mem_done = 1'b1;
    cyc_check("mw_fast", 7'b0000000);
    idle();

    // Load to x0 never marks x0 busy
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 5'd0;
    cyc_check("x0_load", 7'b0000001);
    id_is_load = 1'b0; id_rd = 5'd3; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    cyc_check("x0_read", 7'b0000001);
    idle();

    // Load x7 while wb writes x7: set wins, consumer stalls
    do_reset();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 5'd7; wb_wr_en = 1'b1; wb_rd = 5'd7;
    cyc_check("x7_setclr", 7'b0000001);
    wb_wr_en = 1'b0; id_is_load = 1'b0; id_rd = 5'd8; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    cyc_check("x7_busy", 7'b1101000);
    wb_wr_en = 1'b1;
    cyc_check("x7_wbcyc", 7'b1101000);
    wb_wr_en = 1'b0;
    cyc_check("x7_free", 7'b0000001);
    idle();

    // Icache miss for 20 cycles: decode keeps firing, stall_cnt saturates at 15
    do_reset();
    icache_done = 1'b0; id_valid = 1'b1;
    cyc_check("ic_miss", 7'b1010001);
    for (int i = 1; i < 20; i++) next_cyc();
    icache_done = 1'b1; id_valid = 1'b0;
    @(negedge clk);
    check_val("ic_sat", 32'(stall_cnt), 32'd15);
    next_cyc();
    cyc_check("ic_hold", 7'b0000000);
    @(negedge clk);
    check_val("ic_sat2", 32'(stall_cnt), 32'd15);
    next_cyc();

    // Async reset in the middle of a dcache wait
    do_reset();
    mem_req = 1'b1;
    cyc_check("rw_enter", 7'b1100110);
    cyc_check("rw_wait", 7'b1100110);
    rst = 1'b1;
    #1;
    check_val("rw_outs", {25'd0, outs}, 32'd0);
    check_val("rw_scnt", 32'(stall_cnt), 32'd0);
    next_cyc();
    rst = 1'b0;
    mem_req = 1'b0;
    cyc_check("rw_run", 7'b0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
